thread_wait_scheduler: RTL and testbench

//   Central wait(n) sequencer for lowered SC_THREAD state machines. Up to NUM_THREADS

---
 rtl/thread_wait_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/thread_wait_scheduler.sv | 127 ++++++++++++
 tb/tb_thread_wait_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/thread_wait_pkg.sv
// Shared types and default sizing for the thread wait scheduler.
package thread_wait_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    PENDING  = 2'd2
  } thread_state_e;

  localparam int unsigned DEF_NUM_THREADS = 4;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_STATE_W     = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr_i,
// wrapping to the lowest index. The pointer register lives in the parent.
module rr_arbiter #(
  parameter  int unsigned NUM_THREADS = 4,
  localparam int unsigned ID_W        = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] req_i,
  input  logic [ID_W-1:0]        ptr_i,
  output logic [NUM_THREADS-1:0] grant_o,
  output logic                   any_o
);

  logic found;

  // First pass searches from the pointer upward, second pass wraps to index 0.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      if (!found && req_i[i] && (ID_W'(i) >= ptr_i)) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/thread_wait_scheduler.sv
// Central wait(n) sequencer: per-thread countdown slots with a shared,
// round-robin-arbitrated resume channel.
module thread_wait_scheduler
  import thread_wait_pkg::*;
#(
  parameter  int unsigned NUM_THREADS = DEF_NUM_THREADS,
  parameter  int unsigned CNT_W       = DEF_CNT_W,
  parameter  int unsigned STATE_W     = DEF_STATE_W,
  localparam int unsigned ID_W        = $clog2(NUM_THREADS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         req_valid,
  output logic [NUM_THREADS-1:0]         req_ready,
  input  logic [NUM_THREADS*CNT_W-1:0]   req_count,
  input  logic [NUM_THREADS*STATE_W-1:0] req_state,
  output logic [NUM_THREADS-1:0]         busy,
  output logic                           resume_valid,
  output logic [ID_W-1:0]                resume_id,
  output logic [STATE_W-1:0]             resume_state,
  input  logic                           resume_ready
);

  logic [NUM_THREADS-1:0]         pending;
  logic [NUM_THREADS-1:0]         grant;
  logic                           any_pend;
  logic                           handshake;
  logic [NUM_THREADS*STATE_W-1:0] st_flat;
  logic [ID_W-1:0]                grant_id;
  logic [ID_W-1:0]                arb_ptr;
  logic [ID_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]                hold_id_q;
  logic                           hold_q;

  assign handshake = any_pend & resume_ready;

  for (genvar i = 0; i < int'(NUM_THREADS); i++) begin : g_slot
    thread_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STATE_W-1:0]   st_q, st_d;
    logic [CNT_W-1:0]     req_cnt;

    assign req_cnt = req_count[i*CNT_W +: CNT_W];

    // Slot next-state: accept when idle, count down to 1, release on handshake.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      st_d    = st_q;
      case (state_q)
        IDLE: begin
          if (req_valid[i]) begin
            state_d = COUNTING;
            cnt_d   = (req_cnt == '0) ? CNT_W'(1) : req_cnt;
            st_d    = req_state[i*STATE_W +: STATE_W];
          end
        end
        COUNTING: begin
          if (cnt_q == CNT_W'(1)) state_d = PENDING;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        PENDING: begin
          if (grant[i] && resume_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Slot registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        st_q    <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        st_q    <= st_d;
      end
    end

    assign pending[i]                        = (state_q == PENDING);
    assign req_ready[i]                      = (state_q == IDLE);
    assign busy[i]                           = (state_q != IDLE);
    assign st_flat[i*STATE_W +: STATE_W]     = st_q;
  end

  // A stalled grant pins the arbiter so id/state cannot move under backpressure.
  assign arb_ptr = hold_q ? hold_id_q : rr_ptr_q;

  rr_arbiter #(.NUM_THREADS(NUM_THREADS)) u_arb (
    .req_i   (pending),
    .ptr_i   (arb_ptr),
    .grant_o (grant),
    .any_o   (any_pend)
  );

  // One-hot grant to index and resume-state mux; both zero when nothing is granted.
  always_comb begin
    grant_id     = '0;
    resume_state = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      if (grant[i]) begin
        grant_id     = grant_id | ID_W'(i);
        resume_state = resume_state | st_flat[i*STATE_W +: STATE_W];
      end
    end
  end

  assign resume_valid = any_pend;
  assign resume_id    = grant_id;
  assign rr_ptr_d     = (grant_id == ID_W'(NUM_THREADS - 1)) ? '0 : grant_id + ID_W'(1);

  // RR pointer advances past the winner on handshake; hold tracks a stalled grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q  <= '0;
      hold_q    <= 1'b0;
      hold_id_q <= '0;
    end else begin
      if (handshake) rr_ptr_q <= rr_ptr_d;
      hold_q    <= any_pend & ~resume_ready;
      hold_id_q <= grant_id;
    end
  end

endmodule

// File: tb/tb_thread_wait_scheduler.sv
// Directed bench for thread_wait_scheduler with hand-computed expectations.
module tb_thread_wait_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 32;
  localparam int unsigned IW = 2;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_count;
  logic [N*SW-1:0] req_state;
  logic [N-1:0]    busy;
  logic            resume_valid;
  logic [IW-1:0]   resume_id;
  logic [SW-1:0]   resume_state;
  logic            resume_ready;

  int errors = 0;
  int checks = 0;

  thread_wait_scheduler #(.NUM_THREADS(N), .CNT_W(CW), .STATE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_count    (req_count),
    .req_state    (req_state),
    .busy         (busy),
    .resume_valid (resume_valid),
    .resume_id    (resume_id),
    .resume_state (resume_state),
    .resume_ready (resume_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; sample/drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic chk_res(input string tag, input int id, input logic [SW-1:0] st);
    chk({tag, "_valid"}, 64'(resume_valid), 64'd1);
    chk({tag, "_id"},    64'(resume_id),    64'(id));
    chk({tag, "_state"}, 64'(resume_state), 64'(st));
  endtask

  initial begin
    reset        = 1'b0;
    req_valid    = '0;
    req_count    = '0;
    req_state    = '0;
    resume_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'hF);
    chk("rst_busy",  64'(busy), 64'h0);
    chk("rst_valid", 64'(resume_valid), 64'd0);
    chk("rst_id",    64'(resume_id), 64'd0);
    chk("rst_state", 64'(resume_state), 64'd0);
    reset = 1'b1;

    // 1: thread0 count=4 state=7
    req_valid = 4'b0001; req_count[0 +: CW] = 32'd4; req_state[0 +: SW] = 32'd7;
    tick();
    req_valid = '0;
    chk("t1_ready_acc", 64'(req_ready), 64'hE);
    chk("t1_busy", 64'(busy), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_early", 64'(resume_valid), 64'd0);
    end
    tick();
    chk_res("t1_res", 0, 32'd7);
    tick();
    chk("t1_ready_back", 64'(req_ready), 64'hF);
    chk("t1_valid_off", 64'(resume_valid), 64'd0);

    // 2: thread1 count=0 then count=1, both resume one edge after acceptance
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b0010; req_count[CW +: CW] = 32'(r); req_state[SW +: SW] = 32'(9 + r);
      tick();
      req_valid = '0;
      chk("t2_early", 64'(resume_valid), 64'd0);
      tick();
      chk_res("t2_res", 1, 32'(9 + r));
      tick();
      chk("t2_off", 64'(resume_valid), 64'd0);
    end

    // 3: all four count=2 from pointer 0, then pointer left at 3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_count[i*CW +: CW] = 32'd2; req_state[i*SW +: SW] = 32'(8'h30 + i);
    end
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    tick();
    chk("t3_early", 64'(resume_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_res("t3a", i, 32'(8'h30 + i));
    end
    tick();
    chk("t3a_off", 64'(resume_valid), 64'd0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk_res("t3_single", 2, 32'h32);
    tick();
    req_valid = 4'hF;
    tick();
    req_valid = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_res("t3b", (3 + k) % 4, 32'(8'h30 + ((3 + k) % 4)));
    end
    tick();
    chk("t3b_off", 64'(resume_valid), 64'd0);

    // 4: backpressure on thread2 while thread3 counts (pointer currently 3)
    resume_ready = 1'b0;
    req_count[2*CW +: CW] = 32'd1; req_state[2*SW +: SW] = 32'hA2;
    req_count[3*CW +: CW] = 32'd3; req_state[3*SW +: SW] = 32'hA3;
    req_valid = 4'b1100;
    tick();
    req_valid = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_res("t4_hold", 2, 32'hA2);
      if (k == 3) chk("t4_busy", 64'(busy), 64'hC);
    end
    resume_ready = 1'b1;
    tick();
    chk_res("t4_next", 3, 32'hA3);
    tick();
    chk("t4_off", 64'(resume_valid), 64'd0);

    // 5: req_valid[1] held through PENDING/handshake
    resume_ready = 1'b0;
    req_count[CW +: CW] = 32'd1; req_state[SW +: SW] = 32'h11;
    req_valid = 4'b0010;
    tick();
    req_count[CW +: CW] = 32'd5; req_state[SW +: SW] = 32'h55;
    tick();
    chk("t5_ready_pend", 64'(req_ready[1]), 64'd0);
    chk_res("t5_first", 1, 32'h11);
    tick();
    chk_res("t5_stall", 1, 32'h11);
    resume_ready = 1'b1;
    tick();
    chk("t5_ready_back", 64'(req_ready[1]), 64'd1);
    chk("t5_off", 64'(resume_valid), 64'd0);
    tick();
    req_valid = '0;
    chk("t5_acc", 64'(req_ready[1]), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t5_early", 64'(resume_valid), 64'd0);
    end
    tick();
    chk_res("t5_second", 1, 32'h55);
    tick();
    chk("t5_done", 64'(req_ready), 64'hF);

    // 6: async reset with slots COUNTING/PENDING
    resume_ready = 1'b0;
    req_count[0 +: CW] = 32'd1;  req_state[0 +: SW] = 32'hB0;
    req_count[CW +: CW] = 32'd10; req_count[2*CW +: CW] = 32'd20;
    req_valid = 4'b0111;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk_res("t6_pre", 0, 32'hB0);
    chk("t6_busy_pre", 64'(busy), 64'h7);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(resume_valid), 64'd0);
    chk("t6_rst_id",    64'(resume_id), 64'd0);
    chk("t6_rst_state", 64'(resume_state), 64'd0);
    chk("t6_rst_ready", 64'(req_ready), 64'hF);
    chk("t6_rst_busy",  64'(busy), 64'h0);
    tick();
    reset = 1'b1;
    resume_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk("t6_quiet", 64'(resume_valid), 64'd0);
    end
    req_count[3*CW +: CW] = 32'd2; req_state[3*SW +: SW] = 32'hC3;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    tick();
    chk_res("t6_new", 3, 32'hC3);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
